// File: rtl/dma_addr_gen_n.sv
// DMA address/word-count generator for one channel: address and word counters with
// mode-dependent terminal-count detection, run/done sequencing and optional auto-reinit.
module dma_addr_gen_n #(
  parameter int unsigned WIDTH          = 8,
  parameter bit          AUTO_REINIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] din,
  input  logic             cnt_en,
  output logic [WIDTH-1:0] addr_out,
  output logic [WIDTH-1:0] dout,
  output logic             done,
  output logic             done_pulse,
  output logic             busy,
  output logic             wc_carry
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [2:0] CmdWrCr   = 3'b000;
  localparam logic [2:0] CmdRdCr   = 3'b001;
  localparam logic [2:0] CmdRdWc   = 3'b010;
  localparam logic [2:0] CmdRdAc   = 3'b011;
  localparam logic [2:0] CmdReinit = 3'b100;
  localparam logic [2:0] CmdLdAddr = 3'b101;
  localparam logic [2:0] CmdLdWc   = 3'b110;
  localparam logic [2:0] CmdEnable = 3'b111;

  state_e           state_q, state_d;
  logic [3:0]       cr_q, cr_d;
  logic [WIDTH-1:0] ar_q, ar_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic [WIDTH-1:0] wr_q, wr_d;
  logic [WIDTH-1:0] wc_q, wc_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             done_pulse_q, done_pulse_d;

  logic [1:0] mode;
  logic       addr_dir;
  logic       auto_reinit;
  logic       count;
  logic [3:0] din_cr;

  assign mode        = cr_q[1:0];
  assign addr_dir    = cr_q[2];
  assign auto_reinit = cr_q[3];
  assign din_cr      = 4'(din);

  // Commands take the cycle; the counters only advance on idle command slots.
  assign count = (state_q == StRun) && cnt_en && !cmd_valid;

  always_comb begin
    done = 1'b0;
    unique case (mode)
      2'b00:   done = cnt_en ? (wc_q == WIDTH'(1)) : (wc_q == '0);
      2'b01:   done = (wc_q == wr_q);
      2'b10:   done = (ac_q == wc_q);
      default: done = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cr_d         = cr_q;
    ar_d         = ar_q;
    ac_d         = ac_q;
    wr_d         = wr_q;
    wc_d         = wc_q;
    dout_d       = dout_q;
    done_pulse_d = 1'b0;
    if (cmd_valid) begin
      unique case (cmd)
        CmdWrCr:   cr_d   = {din_cr[3] & AUTO_REINIT_EN, din_cr[2:0]};
        CmdRdCr:   dout_d = WIDTH'(cr_q);
        CmdRdWc:   dout_d = wc_q;
        CmdRdAc:   dout_d = ac_q;
        CmdReinit: begin
          ac_d    = ar_q;
          wc_d    = mode[0] ? '0 : wr_q;
          state_d = StIdle;
        end
        CmdLdAddr: begin
          ar_d = din;
          ac_d = din;
        end
        CmdLdWc: begin
          wr_d = din;
          wc_d = mode[0] ? '0 : din;
        end
        default:   state_d = StRun;
      endcase
    end else if (count) begin
      ac_d = addr_dir ? ac_q - WIDTH'(1) : ac_q + WIDTH'(1);
      unique case (mode)
        2'b00:   wc_d = wc_q - WIDTH'(1);
        2'b10:   wc_d = wc_q;
        default: wc_d = wc_q + WIDTH'(1);
      endcase
      if (done) begin
        done_pulse_d = 1'b1;
        if (auto_reinit) begin
          ac_d = ar_q;
          wc_d = mode[0] ? '0 : wr_q;
        end else begin
          state_d = StDone;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cr_q         <= '0;
      ar_q         <= '0;
      ac_q         <= '0;
      wr_q         <= '0;
      wc_q         <= '0;
      dout_q       <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cr_q         <= cr_d;
      ar_q         <= ar_d;
      ac_q         <= ac_d;
      wr_q         <= wr_d;
      wc_q         <= wc_d;
      dout_q       <= dout_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign addr_out   = ac_q;
  assign dout       = dout_q;
  assign done_pulse = done_pulse_q;
  assign busy       = (state_q == StRun);
  assign wc_carry   = (mode == 2'b11) && cnt_en && (wc_q == '1);

endmodule
